// File: rtl/test_opd_stage.sv
// test_opd_stage: per-operand source selection ahead of the LUT/PE stage.
// Each of operands a, b and c is driven from a constant register, a
// valid-qualified capture register, a combinational bypass, or a
// one-cycle delay register, as selected by the config-written mode fields.
// Optional feature: define TEST_OPD_STAGE_READBACK_EN to add the
// combinational cfg_rd_data readback port.
module test_opd_stage #(
  parameter int DataWidth = 16
) (
  input  logic                 cfg_clk,
  input  logic                 cfg_rst,
  input  logic [31:0]          cfg_d,
  input  logic [7:0]           cfg_a,
  input  logic                 cfg_en,
  input  logic [DataWidth-1:0] data_a_in,
  input  logic [DataWidth-1:0] data_b_in,
  input  logic                 bit_c_in,
  input  logic                 in_valid,
  output logic [DataWidth-1:0] op_a_out,
  output logic [DataWidth-1:0] op_b_out,
  output logic                 op_c_out,
  output logic                 out_valid
`ifdef TEST_OPD_STAGE_READBACK_EN
  ,
  output logic [31:0]          cfg_rd_data
`endif
);

  localparam logic [1:0] ModeConst  = 2'd0;
  localparam logic [1:0] ModeValid  = 2'd1;
  localparam logic [1:0] ModeBypass = 2'd2;
  localparam logic [1:0] ModeDelay  = 2'd3;

  localparam logic [7:0] AddrMode   = 8'hF0;
  localparam logic [7:0] AddrConstA = 8'hF1;
  localparam logic [7:0] AddrConstB = 8'hF2;
  localparam logic [7:0] AddrConstC = 8'hF3;

  logic [1:0]           r_mode_a, r_mode_b, r_mode_c;
  logic [DataWidth-1:0] r_const_a, r_const_b;
  logic                 r_const_c;
  logic [DataWidth-1:0] r_op_a, r_op_b;
  logic                 r_op_c;
  logic                 r_valid_q;

  logic w_cap_a, w_cap_b, w_cap_c;
  logic w_use_valid_q;

  // Capture enables use the mode in effect before any same-edge config write.
  assign w_cap_a = (r_mode_a == ModeDelay) || ((r_mode_a == ModeValid) && in_valid);
  assign w_cap_b = (r_mode_b == ModeDelay) || ((r_mode_b == ModeValid) && in_valid);
  assign w_cap_c = (r_mode_c == ModeDelay) || ((r_mode_c == ModeValid) && in_valid);

  // Any registered operand path means the outputs lag by one cycle.
  assign w_use_valid_q = r_mode_a[0] | r_mode_b[0] | r_mode_c[0];

  // Configuration register file; reset wins over a simultaneous write.
  always_ff @(posedge cfg_clk) begin
    if (cfg_rst) begin
      r_mode_a  <= ModeConst;
      r_mode_b  <= ModeConst;
      r_mode_c  <= ModeConst;
      r_const_a <= '0;
      r_const_b <= '0;
      r_const_c <= 1'b0;
    end else if (cfg_en) begin
      case (cfg_a)
        AddrMode: begin
          r_mode_a <= cfg_d[1:0];
          r_mode_b <= cfg_d[3:2];
          r_mode_c <= cfg_d[5:4];
        end
        AddrConstA: r_const_a <= cfg_d[DataWidth-1:0];
        AddrConstB: r_const_b <= cfg_d[DataWidth-1:0];
        AddrConstC: r_const_c <= cfg_d[0];
        default: ;
      endcase
    end
  end

  // Operand capture registers and valid pipeline; contents survive mode changes.
  always_ff @(posedge cfg_clk) begin
    if (cfg_rst) begin
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_op_c    <= 1'b0;
      r_valid_q <= 1'b0;
    end else begin
      if (w_cap_a) r_op_a <= data_a_in;
      if (w_cap_b) r_op_b <= data_b_in;
      if (w_cap_c) r_op_c <= bit_c_in;
      r_valid_q <= in_valid;
    end
  end

  // Output source selection per operand.
  always_comb begin
    op_a_out = r_const_a;
    op_b_out = r_const_b;
    op_c_out = r_const_c;
    case (r_mode_a)
      ModeBypass: op_a_out = data_a_in;
      ModeValid, ModeDelay: op_a_out = r_op_a;
      default: ;
    endcase
    case (r_mode_b)
      ModeBypass: op_b_out = data_b_in;
      ModeValid, ModeDelay: op_b_out = r_op_b;
      default: ;
    endcase
    case (r_mode_c)
      ModeBypass: op_c_out = bit_c_in;
      ModeValid, ModeDelay: op_c_out = r_op_c;
      default: ;
    endcase
    out_valid = w_use_valid_q ? r_valid_q : in_valid;
  end

`ifdef TEST_OPD_STAGE_READBACK_EN
  // Zero-extended readback of the addressed config register.
  always_comb begin
    cfg_rd_data = '0;
    case (cfg_a)
      AddrMode:   cfg_rd_data[5:0] = {r_mode_c, r_mode_b, r_mode_a};
      AddrConstA: cfg_rd_data[DataWidth-1:0] = r_const_a;
      AddrConstB: cfg_rd_data[DataWidth-1:0] = r_const_b;
      AddrConstC: cfg_rd_data[0] = r_const_c;
      default: ;
    endcase
  end
`endif

endmodule

// File: tb/tb_test_opd_stage.sv
// Directed bench for test_opd_stage (DataWidth=16).
// Inputs change 1 time unit after the rising edge; outputs are checked
// 1 time unit after that, well before the next rising edge.
module tb_test_opd_stage;

  logic        cfg_clk = 1'b0;
  logic        cfg_rst;
  logic [31:0] cfg_d;
  logic [7:0]  cfg_a;
  logic        cfg_en;
  logic [15:0] data_a_in, data_b_in;
  logic        bit_c_in;
  logic        in_valid;
  logic [15:0] op_a_out, op_b_out;
  logic        op_c_out;
  logic        out_valid;
`ifdef TEST_OPD_STAGE_READBACK_EN
  logic [31:0] cfg_rd_data;
`endif

  int n_total = 0;
  int n_bad   = 0;

  test_opd_stage #(.DataWidth(16)) dut (
    .cfg_clk   (cfg_clk),
    .cfg_rst   (cfg_rst),
    .cfg_d     (cfg_d),
    .cfg_a     (cfg_a),
    .cfg_en    (cfg_en),
    .data_a_in (data_a_in),
    .data_b_in (data_b_in),
    .bit_c_in  (bit_c_in),
    .in_valid  (in_valid),
    .op_a_out  (op_a_out),
    .op_b_out  (op_b_out),
    .op_c_out  (op_c_out),
    .out_valid (out_valid)
`ifdef TEST_OPD_STAGE_READBACK_EN
    ,
    .cfg_rd_data (cfg_rd_data)
`endif
  );

  always #5 cfg_clk = ~cfg_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cfg_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cfg_en = 1'b1;
    cfg_a  = a;
    cfg_d  = d;
    step();
    cfg_en = 1'b0;
    cfg_a  = 8'h00;
    cfg_d  = '0;
  endtask

  initial begin
    cfg_rst = 1'b1; cfg_en = 1'b0; cfg_a = '0; cfg_d = '0;
    data_a_in = '0; data_b_in = '0; bit_c_in = 1'b0; in_valid = 1'b0;
    step();
    step();
    cfg_rst = 1'b0;
    settle();
    chk("rst_op_a", 32'(op_a_out), 32'h0);
    chk("rst_op_b", 32'(op_b_out), 32'h0);
    chk("rst_op_c", 32'(op_c_out), 32'h0);
    chk("rst_out_valid0", 32'(out_valid), 32'h0);

    // CONST mode with const_a=0, out_valid follows in_valid combinationally
    data_a_in = 16'h1234; in_valid = 1'b1;
    settle();
    chk("const0_op_a", 32'(op_a_out), 32'h0);
    chk("const0_out_valid", 32'(out_valid), 32'h1);
    in_valid = 1'b0; data_a_in = '0;

    // const_a write: visible only after the write edge
    cfg_en = 1'b1; cfg_a = 8'hF1; cfg_d = 32'h0000BEEF;
    settle();
    chk("consta_before_edge", 32'(op_a_out), 32'h0);
    step();
    cfg_en = 1'b0; cfg_a = 8'h00; cfg_d = '0;
    wr(8'hF0, 32'h0);
    settle();
    chk("consta_beef", 32'(op_a_out), 32'hBEEF);

    // const_b keeps low 16 bits, const_c keeps bit 0; unknown address ignored
    wr(8'hF2, 32'h1234ABCD);
    wr(8'hF3, 32'h00000003);
    wr(8'hF4, 32'hFFFFFFFF);
    settle();
    chk("constb_abcd", 32'(op_b_out), 32'hABCD);
    chk("constc_1", 32'(op_c_out), 32'h1);
    chk("consta_keep", 32'(op_a_out), 32'hBEEF);

    // mode write with only upper bits set leaves all modes CONST
    wr(8'hF0, 32'hFFFFFFC0);
    in_valid = 1'b1;
    settle();
    chk("modehi_op_b", 32'(op_b_out), 32'hABCD);
    chk("modehi_out_valid", 32'(out_valid), 32'h1);
    in_valid = 1'b0;

    // VALID mode on a: stale register first, then qualified capture
    wr(8'hF0, 32'h01);
    settle();
    chk("valid_stale", 32'(op_a_out), 32'h0);
    data_a_in = 16'h0011; in_valid = 1'b1;
    settle();
    chk("valid_outv_lag", 32'(out_valid), 32'h0);
    step();
    data_a_in = 16'h0022; in_valid = 1'b0;
    settle();
    chk("valid_cap1", 32'(op_a_out), 32'h0011);
    chk("valid_outv1", 32'(out_valid), 32'h1);
    step();
    settle();
    chk("valid_hold", 32'(op_a_out), 32'h0011);
    chk("valid_outv0", 32'(out_valid), 32'h0);

    // a VALID, b DELAY, c BYPASS: DELAY captures even with in_valid=0
    wr(8'hF0, 32'h2D);
    data_b_in = 16'd1;
    settle();
    chk("delay_b0", 32'(op_b_out), 32'h0);
    step();
    data_b_in = 16'd2;
    settle();
    chk("delay_b1", 32'(op_b_out), 32'h1);
    step();
    data_b_in = 16'd3;
    settle();
    chk("delay_b2", 32'(op_b_out), 32'h2);
    step();
    settle();
    chk("delay_b3", 32'(op_b_out), 32'h3);
    chk("delay_a_hold", 32'(op_a_out), 32'h0011);
    chk("delay_outv", 32'(out_valid), 32'h0);
    bit_c_in = 1'b1;
    settle();
    chk("bypass_c1", 32'(op_c_out), 32'h1);
    bit_c_in = 1'b0;
    settle();
    chk("bypass_c0", 32'(op_c_out), 32'h0);

    // reset wins over a simultaneous all-DELAY mode write
    cfg_rst = 1'b1; cfg_en = 1'b1; cfg_a = 8'hF0; cfg_d = 32'h3F;
    step();
    cfg_rst = 1'b0; cfg_en = 1'b0; cfg_a = 8'h00; cfg_d = '0;
    data_a_in = 16'h5555; data_b_in = 16'h6666; bit_c_in = 1'b1; in_valid = 1'b1;
    settle();
    chk("rstwr_op_a", 32'(op_a_out), 32'h0);
    chk("rstwr_op_b", 32'(op_b_out), 32'h0);
    chk("rstwr_op_c", 32'(op_c_out), 32'h0);
    chk("rstwr_out_valid", 32'(out_valid), 32'h1);
    step();
    settle();
    chk("rstwr_op_a_next", 32'(op_a_out), 32'h0);
    chk("rstwr_op_b_next", 32'(op_b_out), 32'h0);
    chk("rstwr_op_c_next", 32'(op_c_out), 32'h0);
    in_valid = 1'b0;

`ifdef TEST_OPD_STAGE_READBACK_EN
    wr(8'hF2, 32'h0000ABCD);
    wr(8'hF0, 32'h1B);
    cfg_a = 8'hF0;
    settle();
    chk("rd_mode", cfg_rd_data, 32'h0000001B);
    cfg_a = 8'hF2;
    settle();
    chk("rd_constb", cfg_rd_data, 32'h0000ABCD);
    cfg_a = 8'h10;
    settle();
    chk("rd_other", cfg_rd_data, 32'h0);
    cfg_a = 8'h00;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
